pipe_stage_reg: RTL and testbench

//  Parametrised pipeline stage register for the EX/MEM and MEM/WB boundaries.

---
 rtl/pipe_stage_reg.sv | 88 ++++++++
 tb/tb_pipe_stage_reg.sv | 122 ++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: pipeline stage register with a 2-entry skid buffer; STAGE_PERF_CNT_EN adds stall/flush counters
module pipe_stage_reg #(
  parameter int CTRL_W = 5,
  parameter int DATA_W = 107,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);
  logic main_v_q, main_v_d, skid_v_q, skid_v_d, acc, con;
  logic [CTRL_W-1:0] main_c_q, main_c_d, skid_c_q, skid_c_d;
  logic [DATA_W-1:0] main_d_q, main_d_d, skid_d_q, skid_d_d;
  assign in_ready  = reset & enable & ~flush & ~skid_v_q;
  assign out_valid = reset & enable & ~flush & main_v_q;
  assign out_ctrl  = main_c_q;
  assign out_data  = main_d_q;
  assign acc = in_valid & in_ready;
  assign con = out_valid & out_ready;
  always_comb begin
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    main_c_d = main_c_q;
    main_d_d = main_d_q;
    skid_c_d = skid_c_q;
    skid_d_d = skid_d_q;
    if (con && skid_v_q) begin
      main_c_d = skid_c_q;
      main_d_d = skid_d_q;
      skid_v_d = 1'b0;
    end else if (con) begin
      main_v_d = acc;
      main_c_d = acc ? in_ctrl : main_c_q;
      main_d_d = acc ? in_data : main_d_q;
    end else if (acc && main_v_q) begin
      skid_v_d = 1'b1;
      skid_c_d = in_ctrl;
      skid_d_d = in_data;
    end else if (acc) begin
      main_v_d = 1'b1;
      main_c_d = in_ctrl;
      main_d_d = in_data;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      main_c_q <= '0;
      main_d_q <= '0;
    end else begin
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      main_c_q <= main_c_d;
      main_d_q <= main_d_d;
    end
    skid_c_q <= skid_c_d;
    skid_d_q <= skid_d_d;
  end
`ifdef STAGE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, flush_q;
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (main_v_q && !flush && (!enable || !out_ready) && !(&stall_q)) stall_q <= stall_q + CNT_W'(1);
      if (flush && (main_v_q || skid_v_q) && !(&flush_q)) flush_q <= flush_q + CNT_W'(1);
    end
  end
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed and random stimulus against a queue-based stage model
module tb_pipe_stage_reg;
  localparam int CW = 5, DW = 107, NW = 16;
  typedef logic [CW+DW-1:0] ent_t;
  logic clk = 1'b0, reset, enable, flush, in_valid, in_ready, out_valid, out_ready;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [DW-1:0] in_data, out_data;
  logic [NW-1:0] stall_cnt, flush_cnt;
  int n_chk = 0, n_err = 0;
  ent_t q[$];
  ent_t last;
  int m_stall, m_flush;
  bit known = 0;
`ifdef STAGE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(NW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step(input logic r, en, fl, iv, ordy, input ent_t e);
    bit m_acc, m_con;
    reset = r; enable = en; flush = fl; in_valid = iv; out_ready = ordy;
    {in_ctrl, in_data} = e;
    #2;
    check("in_ready", in_ready, r & en & ~fl & (q.size() < 2));
    check("out_valid", out_valid, r & en & ~fl & (q.size() > 0));
    if (known) begin
      check("out_ctrl", out_ctrl, last[CW+DW-1:DW]);
      check("out_data", out_data, last[DW-1:0]);
      check("stall_cnt", stall_cnt, PERF ? m_stall : 0);
      check("flush_cnt", flush_cnt, PERF ? m_flush : 0);
    end
    @(posedge clk);
    if (!r) begin
      q.delete(); last = '0; m_stall = 0; m_flush = 0; known = 1;
    end else if (fl) begin
      if (q.size() > 0 && m_flush < 65535) m_flush++;
      q.delete(); last = '0;
    end else begin
      if (q.size() > 0 && (!en || !ordy) && m_stall < 65535) m_stall++;
      m_acc = en && iv && q.size() < 2;
      m_con = en && ordy && q.size() > 0;
      if (m_con) void'(q.pop_front());
      if (m_acc) q.push_back(e);
      if (q.size() > 0) last = q[0];
    end
    #1;
  endtask
  function automatic ent_t mk(input int v);
    ent_t e = '0;
    e[DW-1:0] = DW'(v);
    e[CW+DW-1:DW] = CW'(v);
    return e;
  endfunction
  function automatic ent_t rnd();
    return ent_t'({$urandom, $urandom, $urandom, $urandom});
  endfunction
  initial begin
    // T1 reset
    step(0, 1, 0, 0, 0, '0);
    step(0, 1, 0, 0, 0, '0);
    reset = 1; #1;
    check("t1_out_valid", out_valid, 0);
    check("t1_in_ready", in_ready, 1);
    check("t1_out_data", out_data, 0);
    check("t1_out_ctrl", out_ctrl, 0);
    // T2 streaming
    for (int i = 1; i <= 8; i++) step(1, 1, 0, 1, 1, mk(i));
    step(1, 1, 0, 0, 1, '0);
    step(1, 1, 0, 0, 1, '0);
    // T3 skid fill and drain
    step(1, 1, 0, 1, 0, mk('hA));
    step(1, 1, 0, 1, 0, mk('hB));
    step(1, 1, 0, 1, 0, mk('hC));
    step(1, 1, 0, 1, 1, mk('hC));
    step(1, 1, 0, 1, 1, mk('hC));
    step(1, 1, 0, 0, 1, '0);
    // T4 flush from FULL
    step(1, 1, 0, 1, 0, mk('hA));
    step(1, 1, 0, 1, 0, mk('hB));
    step(1, 1, 1, 1, 0, mk('hD));
    in_valid = 0; flush = 0; #1;
    check("t4_out_valid", out_valid, 0);
    check("t4_in_ready", in_ready, 1);
    check("t4_out_data", out_data, 0);
    step(1, 1, 0, 0, 0, '0);
    // T5 stall with enable low
    step(0, 1, 0, 0, 0, '0);
    step(1, 1, 0, 1, 1, mk('h55));
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 1, '0);
    step(1, 1, 0, 0, 1, '0);
    check("t5_stall_cnt", stall_cnt, PERF ? 4 : 0);
    check("t5_out_data", out_data, 'h55);
    check("t5_out_valid", out_valid, 0);
    // T6 reset with flush during FULL
    step(1, 1, 0, 1, 0, mk('h11));
    step(1, 1, 0, 1, 0, mk('h22));
    step(0, 1, 1, 1, 1, mk('h33));
    step(1, 1, 0, 0, 1, '0);
    check("t6_out_data", out_data, 0);
    check("t6_flush_cnt", flush_cnt, 0);
    // random phase
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 49) != 0, $urandom_range(0, 4) != 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, rnd());
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
